// File: rtl/dp_pkg.sv
// Shared datapath parameters, instruction field layout and arbiter FSM states.
package dp_pkg;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 2;
  localparam int unsigned OPW = 3;
  localparam int unsigned IW  = OPW + 3 * AW;

  // Instruction layout: {opcode, ra1, ra2, wa}
  localparam int unsigned WaLsb  = 0;
  localparam int unsigned Ra2Lsb = AW;
  localparam int unsigned Ra1Lsb = 2 * AW;
  localparam int unsigned OpLsb  = 3 * AW;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } arb_state_e;

endpackage

// File: rtl/dp_arbiter_rr_arbiter2.sv
// Two-way round-robin choice; the last-grant pointer lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  always_comb begin
    grant_valid = |req_valid;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last_grant;
    endcase
  end

endmodule

// File: rtl/dp_arbiter.sv
// Shares the RegFile/ALU datapath between the control unit (0) and the host port (1),
// one instruction in flight at a time, with the result returned on a valid/ready channel.
module dp_arbiter #(
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 2,
  parameter int unsigned OPW = 3,
  parameter int unsigned IW  = OPW + 3 * AW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  input  logic [IW-1:0]  req_instr0,
  input  logic [IW-1:0]  req_instr1,
  output logic [1:0]     req_ready,
  output logic [1:0]     rsp_valid,
  output logic [DW-1:0]  rsp_data,
  input  logic [1:0]     rsp_ready,
  output logic [OPW-1:0] dp_opcode,
  output logic [AW-1:0]  dp_ra1,
  output logic [AW-1:0]  dp_ra2,
  output logic [AW-1:0]  dp_wa,
  output logic           dp_we,
  input  logic [DW-1:0]  dp_y,
  output logic           busy,
  output logic           grant_id
);

  import dp_pkg::*;

  arb_state_e    state_q;
  logic          last_grant_q;
  logic          grant_id_q;
  logic [IW-1:0] instr_q;
  logic [DW-1:0] rsp_data_q;

  logic arb_valid;
  logic arb_grant;

  rr_arbiter2 u_rr_arbiter2 (
    .req_valid   (req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      instr_q      <= '0;
      rsp_data_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            instr_q      <= arb_grant ? req_instr1 : req_instr0;
            grant_id_q   <= arb_grant;
            last_grant_q <= arb_grant;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          // RegFile writes on this same edge, so dp_y is still the pre-write read.
          rsp_data_q <= dp_y;
          state_q    <= StResp;
        end
        StResp: begin
          if (rsp_ready[grant_id_q]) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs are forced low while reset is asserted, aborting any transaction.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (reset && (state_q == StIdle) && arb_valid) req_ready[arb_grant] = 1'b1;
    if (reset && (state_q == StResp)) rsp_valid[grant_id_q] = 1'b1;
  end

  assign dp_we     = reset && (state_q == StIssue);
  assign busy      = reset && (state_q != StIdle);
  assign grant_id  = grant_id_q;
  assign rsp_data  = rsp_data_q;
  assign dp_opcode = instr_q[OpLsb +: OPW];
  assign dp_ra1    = instr_q[Ra1Lsb +: AW];
  assign dp_ra2    = instr_q[Ra2Lsb +: AW];
  assign dp_wa     = instr_q[WaLsb +: AW];

endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: RegFile/ALU environment, two queued requesters, and a
// transaction-level model checked every negative clock edge.
module tb_dp_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [8:0] req_instr0;
  logic [8:0] req_instr1;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_ready;
  logic [2:0] dp_opcode;
  logic [1:0] dp_ra1;
  logic [1:0] dp_ra2;
  logic [1:0] dp_wa;
  logic       dp_we;
  logic [7:0] dp_y;
  logic       busy;
  logic       grant_id;

  always #5 clk = ~clk;

  dp_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_instr0 (req_instr0),
    .req_instr1 (req_instr1),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .dp_opcode  (dp_opcode),
    .dp_ra1     (dp_ra1),
    .dp_ra2     (dp_ra2),
    .dp_wa      (dp_wa),
    .dp_we      (dp_we),
    .dp_y       (dp_y),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a,
                                     input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // Datapath environment: RegFile with a bench-side preload port.
  logic [7:0] rf [4];
  logic       bw_en = 1'b0;
  logic [1:0] bw_a = '0;
  logic [7:0] bw_d = '0;

  always @(posedge clk) begin
    if (dp_we) rf[dp_wa] <= dp_y;
    else if (bw_en) rf[bw_a] <= bw_d;
  end

  assign dp_y = alu(dp_opcode, rf[dp_ra1], rf[dp_ra2]);

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: each presents its queue head until accepted.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         h0 = 0;
  int         h1 = 0;
  logic [1:0] acc_mask = 2'b00;

  always @(posedge clk) begin
    #1;
    if (acc_mask[0]) h0++;
    if (acc_mask[1]) h1++;
    req_valid[0] = h0 < q0.size();
    req_valid[1] = h1 < q1.size();
    req_instr0   = (h0 < q0.size()) ? q0[h0] : 9'd0;
    req_instr1   = (h1 < q1.size()) ? q1[h1] : 9'd0;
  end

  // Reference model: phase 0 = waiting, 1 = datapath cycle, 2 = result offered.
  int         m_phase = 0;
  logic       m_last = 1'b1;
  logic       m_owner = 1'b0;
  logic [8:0] m_instr = '0;
  logic [7:0] m_result = '0;
  logic [7:0] mreg [4];
  int         pick;
  logic [1:0] exp_ready;

  int         acc_id[$];
  int         acc_cyc[$];
  logic [7:0] rsp_log[$];
  int         rsp_cnt = 0;

  task automatic chk_fields();
    chk("dp_opcode", dp_opcode, m_instr[8:6]);
    chk("dp_ra1", dp_ra1, m_instr[5:4]);
    chk("dp_ra2", dp_ra2, m_instr[3:2]);
    chk("dp_wa", dp_wa, m_instr[1:0]);
  endtask

  always @(negedge clk) begin
    acc_mask = req_valid & req_ready;
    if (acc_mask != 2'b00) begin
      acc_id.push_back(acc_mask[1] ? 1 : 0);
      acc_cyc.push_back(cyc);
    end
    if ((rsp_valid & rsp_ready) != 2'b00) begin
      rsp_cnt++;
      rsp_log.push_back(rsp_data);
    end
    if (bw_en) mreg[bw_a] = bw_d;

    if (!reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_dp_we", dp_we, 0);
      chk("rst_busy", busy, 0);
      m_phase  = 0;
      m_last   = 1'b1;
      m_owner  = 1'b0;
      m_instr  = '0;
      m_result = '0;
    end else if (m_phase == 0) begin
      // Tie goes to whoever was not granted last.
      if (req_valid == 2'b11) pick = m_last ? 0 : 1;
      else pick = req_valid[1] ? 1 : 0;
      exp_ready = req_valid[pick] ? (2'b01 << pick) : 2'b00;
      chk("idle_req_ready", req_ready, exp_ready);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_dp_we", dp_we, 0);
      chk("idle_busy", busy, 0);
      chk_fields();
      if (req_valid[pick]) begin
        m_instr = pick ? req_instr1 : req_instr0;
        m_owner = pick[0];
        m_last  = pick[0];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      chk("issue_dp_we", dp_we, 1);
      chk("issue_busy", busy, 1);
      chk("issue_req_ready", req_ready, 0);
      chk("issue_rsp_valid", rsp_valid, 0);
      chk("issue_grant_id", grant_id, m_owner);
      chk_fields();
      m_result = alu(m_instr[8:6], mreg[m_instr[5:4]], mreg[m_instr[3:2]]);
      mreg[m_instr[1:0]] = m_result;
      m_phase = 2;
    end else begin
      chk("resp_rsp_valid", rsp_valid, 2'b01 << m_owner);
      chk("resp_rsp_data", rsp_data, m_result);
      chk("resp_busy", busy, 1);
      chk("resp_dp_we", dp_we, 0);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_grant_id", grant_id, m_owner);
      chk_fields();
      if (rsp_ready[m_owner]) m_phase = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_reg(input logic [1:0] a, input logic [7:0] v);
    bw_a  = a;
    bw_d  = v;
    bw_en = 1'b1;
    tick();
    bw_en = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int i = 0;
    while (acc_id.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk(name, acc_id.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i = 0;
    while ((busy || h0 < q0.size() || h1 < q1.size()) && i < budget) begin
      tick();
      i++;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int rbase;
    int rc;
    reset     = 1'b0;
    rsp_ready = 2'b11;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_dp_wa", dp_wa, 0);
    reset = 1'b1;
    set_reg(0, 0);
    set_reg(3, 0);
    set_reg(1, 5);
    set_reg(2, 7);

    // Single r0 ADD R1+R2 -> R3.
    q0.push_back({3'd0, 2'd1, 2'd2, 2'd3});
    wait_acc(1, 10, "t1_accept");
    chk("t1_issue_we", dp_we, 1);
    chk("t1_issue_wa", dp_wa, 3);
    tick();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data, 12);
    chk("t1_we_once", dp_we, 0);
    tick();
    chk("t1_rf3", rf[3], 12);

    // Continuous tie for 6 transactions after a fresh reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    base = acc_id.size();
    q0.push_back({3'd1, 2'd2, 2'd1, 2'd0});
    q0.push_back({3'd3, 2'd0, 2'd3, 2'd2});
    q0.push_back({3'd4, 2'd3, 2'd2, 2'd0});
    q1.push_back({3'd0, 2'd3, 2'd1, 2'd3});
    q1.push_back({3'd2, 2'd2, 2'd3, 2'd0});
    q1.push_back({3'd5, 2'd1, 2'd0, 2'd2});
    wait_acc(base + 6, 40, "t2_accept6");
    for (int k = 0; k < 6; k++) chk("t2_alternate", acc_id[base+k], k % 2);
    wait_idle(20, "t2_idle");

    // r1 response held off for 10 cycles while r0 waits.
    set_reg(3, 20);
    set_reg(0, 6);
    rsp_ready = 2'b01;
    base = acc_id.size();
    q1.push_back({3'd1, 2'd3, 2'd0, 2'd2});
    wait_acc(base + 1, 10, "t3_accept_r1");
    q0.push_back({3'd0, 2'd1, 2'd1, 2'd3});
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold_valid", rsp_valid, 2'b10);
      chk("t3_hold_data", rsp_data, 14);
      chk("t3_hold_busy", busy, 1);
      chk("t3_hold_ready", req_ready, 0);
      chk("t3_hold_we", dp_we, 0);
      tick();
    end
    rsp_ready = 2'b11;
    wait_acc(base + 2, 10, "t3_accept_r0");
    chk("t3_second_id", acc_id[base+1], 0);
    wait_idle(20, "t3_idle");
    chk("t3_r0_result", rsp_log[rsp_log.size()-1], 10);

    // Back-to-back r0 with dependent reads.
    set_reg(1, 3);
    set_reg(2, 4);
    base  = acc_id.size();
    rbase = rsp_log.size();
    q0.push_back({3'd0, 2'd1, 2'd2, 2'd0});
    q0.push_back({3'd0, 2'd0, 2'd0, 2'd3});
    q0.push_back({3'd1, 2'd3, 2'd1, 2'd2});
    wait_acc(base + 3, 20, "t4_accept3");
    chk("t4_spacing_a", acc_cyc[base+1] - acc_cyc[base], 3);
    chk("t4_spacing_b", acc_cyc[base+2] - acc_cyc[base+1], 3);
    wait_idle(20, "t4_idle");
    chk("t4_rsp_count", rsp_log.size() - rbase, 3);
    if (rsp_log.size() - rbase == 3) begin
      chk("t4_res0", rsp_log[rbase], 7);
      chk("t4_res1", rsp_log[rbase+1], 14);
      chk("t4_res2", rsp_log[rbase+2], 11);
    end

    // Reset during the datapath cycle: no write, no response.
    set_reg(3, 0);
    set_reg(1, 1);
    set_reg(2, 2);
    rc   = rsp_cnt;
    base = acc_id.size();
    q0.push_back({3'd0, 2'd1, 2'd2, 2'd3});
    wait_acc(base + 1, 10, "t5_accept_a");
    reset = 1'b0;
    tick();
    chk("t5a_busy", busy, 0);
    chk("t5a_rsp_valid", rsp_valid, 0);
    reset = 1'b1;
    tick();
    chk("t5a_no_write", rf[3], 0);
    chk("t5a_no_rsp", rsp_cnt, rc);

    // Reset while the result is offered: write stands, response dropped.
    q0.push_back({3'd0, 2'd1, 2'd2, 2'd0});
    wait_acc(base + 2, 10, "t5_accept_b");
    tick();
    reset = 1'b0;
    tick();
    chk("t5b_busy", busy, 0);
    chk("t5b_rsp_valid", rsp_valid, 0);
    reset = 1'b1;
    tick();
    chk("t5b_no_rsp", rsp_cnt, rc);
    chk("t5b_write", rf[0], 3);
    base = acc_id.size();
    q1.push_back({3'd2, 2'd1, 2'd2, 2'd1});
    q0.push_back({3'd3, 2'd1, 2'd2, 2'd2});
    wait_acc(base + 1, 10, "t5_tie_accept");
    chk("t5_tie_r0_first", acc_id[base], 0);
    wait_idle(20, "t5_idle");

    // Destination equals first source.
    set_reg(1, 4);
    base = acc_id.size();
    q0.push_back({3'd0, 2'd1, 2'd1, 2'd1});
    wait_acc(base + 1, 10, "t6_accept");
    tick();
    chk("t6_rsp_valid", rsp_valid, 2'b01);
    chk("t6_rsp_data", rsp_data, 8);
    tick();
    chk("t6_rf1", rf[1], 8);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
